// File: rtl/video_out_stage_if.sv
// Video output stage interface.
// Groups the pixel-pipeline side (sync/blank/colour in) and the VGA pin side
// (polarity-adjusted sync, blank, gated colour, primed flag) into one bundle.
//   master : pixel pipeline / bench - drives *_in, observes *_out and primed
//   slave  : video_out_stage        - consumes *_in, drives *_out and primed
interface video_out_stage_if #(
    parameter int unsigned RGB_W = 24
);
    logic             hsync_in;
    logic             vsync_in;
    logic             blnk_in;
    logic [RGB_W-1:0] rgb_in;
    logic             hsync_out;
    logic             vsync_out;
    logic             blnk_out;
    logic [RGB_W-1:0] rgb_out;
    logic             primed;

    modport master (
        output hsync_in, vsync_in, blnk_in, rgb_in,
        input  hsync_out, vsync_out, blnk_out, rgb_out, primed
    );

    modport slave (
        input  hsync_in, vsync_in, blnk_in, rgb_in,
        output hsync_out, vsync_out, blnk_out, rgb_out, primed
    );
endinterface

// File: rtl/video_out_stage.sv
// Final video output stage between the pixel pipeline and the VGA pins.
// Delays the sync/blank path and the RGB path by independent depths, registers
// the result on the selected launch edge, applies sync polarity, blacks out RGB
// during blanking and holds all outputs inactive until both delay lines have
// been refilled after reset.
// Ports:
//   clk    : pixel clock
//   rst    : asynchronous reset, active-high
//   vid_io : slave side of video_out_stage_if
//            in : hsync_in, vsync_in (active-high), blnk_in, rgb_in
//            out: hsync_out, vsync_out (polarity-adjusted), blnk_out,
//                 rgb_out (gated), primed
module video_out_stage #(
    parameter int unsigned RGB_W       = 24,
    parameter int unsigned SYNC_DLY    = 2,    // 1..15
    parameter int unsigned RGB_DLY     = 2,    // 1..15
    parameter bit          OUT_NEGEDGE = 1'b1,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter bit          BLANK_RGB   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    video_out_stage_if.slave   vid_io
);

    localparam int unsigned MaxD    = (SYNC_DLY > RGB_DLY) ? SYNC_DLY : RGB_DLY;
    localparam logic [3:0]  MaxDCnt = 4'(MaxD);

    // Sync line entries are {hsync, vsync, blnk}; RGB line entries are {rgb_blank, rgb}.
    logic [2:0]     sync_q [SYNC_DLY];
    logic [RGB_W:0] rgb_q  [RGB_DLY];
    logic [3:0]     cnt_q, cnt_d;
    logic           primed_int;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blnk_q, blnk_d;
    logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
    logic             primed_q, primed_d;

    // Delay lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DLY; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {vid_io.hsync_in, vid_io.vsync_in, vid_io.blnk_in};
            for (int i = 1; i < SYNC_DLY; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RGB_DLY; i++) rgb_q[i] <= '0;
        end else begin
            rgb_q[0] <= {vid_io.blnk_in, vid_io.rgb_in};
            for (int i = 1; i < RGB_DLY; i++) rgb_q[i] <= rgb_q[i-1];
        end
    end

    // Priming counter: saturates at MaxD, so primed_int means every stage of
    // both lines holds data sampled after reset release.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != MaxDCnt) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign primed_int = (cnt_q == MaxDCnt);

    // Output register next-state: inactive set until primed.
    always_comb begin
        hs_d      = ~HS_POL;
        vs_d      = ~VS_POL;
        blnk_d    = 1'b1;
        rgb_out_d = '0;
        primed_d  = 1'b0;
        if (primed_int) begin
            hs_d     = sync_q[SYNC_DLY-1][2] ~^ HS_POL;
            vs_d     = sync_q[SYNC_DLY-1][1] ~^ VS_POL;
            blnk_d   = sync_q[SYNC_DLY-1][0];
            primed_d = 1'b1;
            if (!(BLANK_RGB && rgb_q[RGB_DLY-1][RGB_W])) begin
                rgb_out_d = rgb_q[RGB_DLY-1][RGB_W-1:0];
            end
        end
    end

    // Launch edge selection; negedge launch gives the pins half a cycle of
    // setup margin relative to the posedge-based pipeline.
    if (OUT_NEGEDGE) begin : g_out_neg
        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                hs_q      <= ~HS_POL;
                vs_q      <= ~VS_POL;
                blnk_q    <= 1'b1;
                rgb_out_q <= '0;
                primed_q  <= 1'b0;
            end else begin
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blnk_q    <= blnk_d;
                rgb_out_q <= rgb_out_d;
                primed_q  <= primed_d;
            end
        end
    end else begin : g_out_pos
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hs_q      <= ~HS_POL;
                vs_q      <= ~VS_POL;
                blnk_q    <= 1'b1;
                rgb_out_q <= '0;
                primed_q  <= 1'b0;
            end else begin
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blnk_q    <= blnk_d;
                rgb_out_q <= rgb_out_d;
                primed_q  <= primed_d;
            end
        end
    end

    assign vid_io.hsync_out = hs_q;
    assign vid_io.vsync_out = vs_q;
    assign vid_io.blnk_out  = blnk_q;
    assign vid_io.rgb_out   = rgb_out_q;
    assign vid_io.primed    = primed_q;

endmodule

// File: doc/video_out_stage.md
Name: video_out_stage

Overview:
- Parametrised final video output stage. It sits between the pixel pipeline (sprite/background mixer) and the Basys3 VGA pins.
- Delays the sync/blank path and the RGB path by independently configurable depths so they align with pixel-pipeline latency.
- Selects the launch edge (negedge or posedge), applies sync polarity, forces RGB to black during blanking, and masks outputs until its pipelines have filled after reset.

Parameters:
- RGB_W, 24, width of rgb_in/rgb_out.
- SYNC_DLY, 2, posedge delay stages on hsync/vsync/blank path; legal range 1..15.
- RGB_DLY, 2, posedge delay stages on RGB path; legal range 1..15.
- OUT_NEGEDGE, 1, 1 = output register clocked on negedge clk; 0 = posedge.
- HS_POL, 0, output hsync polarity: 1 = active-high, 0 = active-low.
- VS_POL, 0, output vsync polarity, same encoding as HS_POL.
- BLANK_RGB, 1, 1 = rgb_out forced to 0 while the RGB-aligned blank is high.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- hsync_in  in  1  horizontal sync, internally active-high
- vsync_in  in  1  vertical sync, internally active-high
- blnk_in  in  1  blanking, active-high
- rgb_in  in  RGB_W  pixel colour
- hsync_out  out  1  polarity-adjusted hsync
- vsync_out  out  1  polarity-adjusted vsync
- blnk_out  out  1  blank, aligned with sync path
- rgb_out  out  RGB_W  gated pixel colour
- primed  out  1  high once both delay lines hold post-reset data

Behaviour:
- Sync delay line:
  - SYNC_DLY posedge stages carry {hsync, vsync, blnk}.
  - Stage 1 samples the inputs; stage k samples stage k-1.
- RGB delay line:
  - RGB_DLY posedge stages carry rgb and a private copy of blnk_in (rgb_blank).
  - rgb_blank is used only for gating.
- Output register:
  - Captures the last stage of each line on negedge clk when OUT_NEGEDGE=1, otherwise on posedge.
- Latency from the posedge that samples an input:
  - OUT_NEGEDGE=1: D-0.5 cycles (output changes at the negedge after posedge n+D-1), where D is the path's delay depth.
  - OUT_NEGEDGE=0: D cycles.
- Polarity: hsync_out = hs_d XNOR HS_POL, i.e. inverted when HS_POL=0. vsync_out uses VS_POL the same way.
- RGB gating: rgb_out = (BLANK_RGB && rgb_blank_d) ? 0 : rgb_d.
- Priming counter:
  - Saturating counter, width 4, cleared by rst.
  - Increments on each posedge until it equals MAXD = max(SYNC_DLY, RGB_DLY).
  - primed_int = (count == MAXD). primed is registered in the output register, so it shares the output edge.
- While primed_int is low, the output register loads the inactive set: hsync_out = ~HS_POL, vsync_out = ~VS_POL, blnk_out = 1, rgb_out = 0.
- Reset (async, immediate):
  - All delay stages 0, counter 0.
  - Outputs: hsync_out = ~HS_POL, vsync_out = ~VS_POL, blnk_out = 1, rgb_out = 0, primed = 0.
- Reset asserted mid-frame: outputs go to the reset values immediately, with no partial-cycle glitch beyond the async clear. After release, priming restarts from 0.
- SYNC_DLY != RGB_DLY: each path is delayed independently. The priming mask lasts MAXD cycles regardless.
- No enable or stall input. The block runs every clock; the counter saturates and never wraps.

Test Plan:
- Reset held, random inputs, HS_POL=VS_POL=0 -> hsync_out=1, vsync_out=1, blnk_out=1, rgb_out=0, primed=0 on both edges.
- Defaults, reset released, rgb_in=24'hFF0000 from posedge 0 -> rgb_out stays 0 and primed=0 until the negedge after posedge 1. From that negedge, primed=1 and rgb_out=24'hFF0000.
- SYNC_DLY=1, RGB_DLY=3, OUT_NEGEDGE=0, hsync_in pulse sampled at posedge 10, rgb_in=24'h00FF00 sampled at posedge 10 -> hsync_out low at posedge 11 (active-low), rgb_out=24'h00FF00 at posedge 13.
- Defaults, blnk_in=1 with rgb_in=24'hFFFFFF -> rgb_out=0 and blnk_out=1 at the same negedge. With BLANK_RGB=0 -> rgb_out=24'hFFFFFF.
- HS_POL=1, VS_POL=1, vsync_in=1 -> vsync_out=1 after 1.5 cycles. Reset value of vsync_out is 0.
- Assert rst mid-line while rgb_out=24'h123456 -> rgb_out=0 immediately. After release, primed returns only after MAXD posedges plus the output edge.
